// File: rtl/la_capture_ctrl_pkg.sv
// Shared definitions for the logic analyzer capture sequencer.
// The state encodings are software-visible through the status register, so the
// register block and firmware headers must agree with these values.
package la_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    LA_IDLE = 2'd0,
    LA_PRE  = 2'd1,
    LA_POST = 2'd2,
    LA_DONE = 2'd3
  } la_state_e;

  // Bit positions of the arm/abort commands in the command register.
  localparam int LA_CMD_ARM_BIT   = 0;
  localparam int LA_CMD_ABORT_BIT = 1;

  // Saturating increment used for the captured-sample count.
  function automatic logic [31:0] la_sat_inc(input logic [31:0] value,
                                             input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/la_capture_ctrl_trigger_match.sv
// Masked-value trigger compare. Purely combinational so that a future
// multi-stage trigger can drop in behind the same ports.
module la_trigger_match #(
  parameter int PROBE_WIDTH = 72
) (
  input  logic [PROBE_WIDTH-1:0] i_data,
  input  logic [PROBE_WIDTH-1:0] i_mask,
  input  logic [PROBE_WIDTH-1:0] i_value,
  output logic                   o_match
);

  logic [PROBE_WIDTH-1:0] w_diff;

  // Differences only count on bits selected by the mask; an all-zero mask matches anything.
  always_comb begin
    w_diff  = (i_data ^ i_value) & i_mask;
    o_match = ~|w_diff;
  end

endmodule

// File: rtl/la_capture_ctrl.sv
// Trigger/capture sequencer for the on-chip logic analyzer.
// Records probe samples into a circular RAM while armed, stops after a
// programmable number of post-trigger samples and reports the trigger address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no capture in progress, RAM not written
// PRE     | writing every valid sample, waiting for the trigger match
// POST    | writing post-trigger samples until the counter runs out
// DONE    | capture frozen, trig_addr / samples_captured held
module la_capture_ctrl
  import la_capture_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int PROBE_WIDTH = 72
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_arm,
  input  logic                   cmd_abort,
  input  logic [PROBE_WIDTH-1:0] trig_mask,
  input  logic [PROBE_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0]  post_count,
  input  logic                   probe_valid,
  input  logic [PROBE_WIDTH-1:0] probe_data,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [PROBE_WIDTH-1:0] mem_wr_data,
  output logic [1:0]             state_out,
  output logic [ADDR_WIDTH-1:0]  trig_addr,
  output logic [ADDR_WIDTH:0]    samples_captured,
  output logic                   done
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  la_state_e               r_state;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_post_cnt;
  logic                    r_mem_wr_en;
  logic [ADDR_WIDTH-1:0]   r_mem_wr_addr;
  logic [PROBE_WIDTH-1:0]  r_mem_wr_data;
  logic [ADDR_WIDTH-1:0]   r_trig_addr;
  logic [ADDR_WIDTH:0]     r_samples;
  logic                    r_done;

  logic                    w_match;
  logic                    w_trigger;
  logic [ADDR_WIDTH-1:0]   w_post_load;
  logic [ADDR_WIDTH:0]     w_samples_inc;

  la_trigger_match #(
    .PROBE_WIDTH (PROBE_WIDTH)
  ) u_trigger_match (
    .i_data  (probe_data),
    .i_mask  (trig_mask),
    .i_value (trig_value),
    .o_match (w_match)
  );

  // Trigger qualification, post-count load value and saturating sample count.
  always_comb begin
    w_trigger     = probe_valid && w_match;
    // post_count is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
    // wider software values are already truncated at the register boundary.
    // That keeps the trigger word from being overwritten by its own post window.
    w_post_load   = post_count;
    w_samples_inc = (r_samples == LP_DEPTH) ? LP_DEPTH : r_samples + (ADDR_WIDTH+1)'(1);
  end

  // Capture sequencer: state, write port, trigger address and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LA_IDLE;
      r_wr_ptr      <= '0;
      r_post_cnt    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_trig_addr   <= '0;
      r_samples     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_mem_wr_en <= 1'b0;
      if (cmd_abort) begin
        // Abort wins over a simultaneous arm; RAM contents are left as they are.
        r_state <= LA_IDLE;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          LA_IDLE, LA_DONE: begin
            if (cmd_arm) begin
              r_state   <= LA_PRE;
              r_wr_ptr  <= '0;
              r_samples <= '0;
              r_done    <= 1'b0;
            end
          end
          LA_PRE: begin
            if (probe_valid) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= r_wr_ptr;
              r_mem_wr_data <= probe_data;
              r_wr_ptr      <= r_wr_ptr + ADDR_WIDTH'(1);
              r_samples     <= w_samples_inc;
              if (w_trigger) begin
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= w_post_load;
                if (w_post_load == '0) begin
                  r_state <= LA_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= LA_POST;
                end
              end
            end
          end
          LA_POST: begin
            if (probe_valid) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= r_wr_ptr;
              r_mem_wr_data <= probe_data;
              r_wr_ptr      <= r_wr_ptr + ADDR_WIDTH'(1);
              r_samples     <= w_samples_inc;
              r_post_cnt    <= r_post_cnt - ADDR_WIDTH'(1);
              if (r_post_cnt == ADDR_WIDTH'(1)) begin
                r_state <= LA_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= LA_IDLE;
          end
        endcase
      end
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    mem_wr_en        = r_mem_wr_en;
    mem_wr_addr      = r_mem_wr_addr;
    mem_wr_data      = r_mem_wr_data;
    state_out        = r_state;
    trig_addr        = r_trig_addr;
    samples_captured = r_samples;
    done             = r_done;
  end

endmodule
